ro_puf: RTL and testbench
=========================

# ro_puf

Behavioural ring-oscillator physical unclonable function (RO PUF). On a start request it runs a bank of 16 deterministic oscillator models for a fixed measurement window. It then produces a 256-bit response by pairwise comparison of oscillator counts, with index permutation selected by an 8-bit challenge. It sits as a leaf block beside the key/identity logic and is fully simulatable, with no combinational loops.

## Interface
- `WINDOW`, 64: measurement window length in clock cycles; legal range 1..3840.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  measurement request; level input, acted on at its rising edge.
- `challenge`  in  8  challenge; latched when a request is accepted.
- `response`  out  256  registered response; holds its value until the next completion.
- `busy`  out  1  high while a measurement is in progress.
- `done`  out  1  one-cycle pulse when `response` has just been updated.

## Operation
- Oscillator model i (i = 0..15) is a 16-bit counter. Each MEASURE cycle it adds `INC[i]`.
- `INC` = {8,13,4,16,1,10,6,15,2,11,14,3,9,12,5,7}, indexed 0..15. It is a permutation of 1..16, so no two rates are equal.
- Start detection:
  - A registered copy `start_q` is kept.
  - A request is `start & ~start_q` sampled while in IDLE.
  - Requests in any other state are ignored.
  - A level held high triggers once only.
- States:
  - IDLE: on a request, latch `challenge`, clear all counters, clear the window counter, go to MEASURE.
  - MEASURE: counters accumulate for exactly `WINDOW` cycles, then go to COMPARE.
  - COMPARE: register the response, pulse `done`, return to IDLE.
- Response bit k (k = 0..255):
  - Split k as a = k[7:4], b = k[3:0].
  - Let ca = challenge_latched[7:4], cb = challenge_latched[3:0].
  - response[k] = 1 iff cnt[a ^ ca] > cnt[b ^ cb] (strict, unsigned).
  - Equal counts give 0.
- Without noise, counts equal INC×WINDOW. Each of the 256 pair-orderings therefore appears once, so every response has exactly 120 ones.
- `busy` = 1 in MEASURE and COMPARE.

## Timing
- Reset values: `response` = 0, `busy` = 0, `done` = 0, state IDLE, counters 0, `start_q` = 0.
- A `start` held high through reset release triggers a measurement on the first cycle after reset.
- Request sampled at edge T:
  - `busy` rises after T.
  - Counters accumulate on edges T+1..T+WINDOW.
  - `response` and `done` update at edge T+WINDOW+1, and `busy` falls there.
  - `done` clears at T+WINDOW+2.
- Earliest next request is sampled at T+WINDOW+2. This requires `start` to have been seen low at some edge since the previous request.
- `rst` asserted mid-MEASURE or mid-COMPARE:
  - Aborts on the next edge.
  - Zeroes `response`.
  - No `done` is issued.
- `challenge` changes after acceptance have no effect on the running measurement.

## Configuration
- `PUF_NOISE_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset and on each request) steps every MEASURE cycle.
  - The oscillator with index LFSR[3:0] gains an extra +1 that cycle.
  - This models jitter; ties and flips become possible, so the 120-ones property no longer holds.
- `PUF_NOISE_EN` undefined: no LFSR is present and counts are exactly INC×WINDOW.
- Interface and latency are identical either way.

## Structure
- Package `ro_puf_pkg`: `INC` table, counter width (16), oscillator count (16), state enum {IDLE, MEASURE, COMPARE}, LFSR seed and taps.
- Sub-module `ro_model`: one oscillator counter with clear, enable, rate and optional jitter-increment input. It is instantiated 16 times by generate.
- The top level holds the FSM, window counter, challenge latch, comparator array and response register.

## Test plan
- Reset: assert `rst` 2 cycles -> `response` = 0, `busy` = 0, `done` = 0; no activity while `start` stays low.
- challenge 0x00, WINDOW = 64, start pulse -> `done` exactly 65 cycles after the accept edge; response[0x34] = 1 (16 > 1), response[0x43] = 0, all response[0xNN with a = b] = 0, popcount 120.
- challenge 0x3C, `start` high 3 cycles -> exactly one measurement; response[0x00] = 1 (cnt3 = 1024 > cnt12 = 576), response[0x3C] = 0 (tie), popcount 120.
- `start` toggled and `challenge` changed during MEASURE -> ignored; result matches the originally latched challenge; single `done`.
- `rst` mid-MEASURE -> `busy` = 0 and `response` = 0 next cycle, no `done`; a fresh request then completes normally.
- WINDOW = 1 -> `done` 2 cycles after accept; response identical to the WINDOW = 64 result for the same challenge.

Source files
------------

// File: rtl/ro_puf_pkg.sv
// Shared constants and types for the ring-oscillator PUF.
// Optional jitter model is enabled with the PUF_NOISE_EN macro (see ro_puf.sv).
package ro_puf_pkg;

  localparam int N_OSC  = 16;
  localparam int CNT_W  = 16;
  localparam int RATE_W = 5;
  // Enough bits for the largest legal window (3840).
  localparam int WIN_W  = 12;

  // Per-oscillator increment; a permutation of 1..16, so all rates differ.
  localparam logic [RATE_W-1:0] INC [N_OSC] = '{
    5'd8, 5'd13, 5'd4, 5'd16, 5'd1, 5'd10, 5'd6, 5'd15,
    5'd2, 5'd11, 5'd14, 5'd3, 5'd9, 5'd12, 5'd5, 5'd7
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    COMPARE = 2'd2
  } state_t;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (taps at bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ro_model.sv
// One behavioural oscillator: a counter that advances by a fixed rate
// (plus an optional one-count jitter) on every enabled cycle.
module ro_model
  import ro_puf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  input  logic              jitter,
  output logic [CNT_W-1:0]  cnt
);

  // Accumulate rate (+jitter) while enabled; clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(rate) + CNT_W'(jitter);
    end
  end

endmodule

// File: rtl/ro_puf.sv
// Ring-oscillator PUF top: request detection, measurement window,
// challenge-permuted pairwise comparison and response register.
// Define PUF_NOISE_EN to add LFSR-driven jitter to the oscillators.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a rising edge on start
// MEASURE | oscillators accumulate for WINDOW cycles
// COMPARE | response registered, done pulsed, back to IDLE
module ro_puf
  import ro_puf_pkg::*;
#(
  parameter int unsigned WINDOW = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   challenge,
  output logic [255:0] response,
  output logic         busy,
  output logic         done
);

  localparam logic [WIN_W-1:0] WIN_INIT = WIN_W'(WINDOW - 1);

  state_t             state, state_nxt;
  logic               start_q;
  logic [7:0]         ch_q;
  logic [WIN_W-1:0]   win_cnt;
  logic               req;
  logic               osc_clr;
  logic               osc_en;
  logic [N_OSC-1:0]   jit;
  logic [CNT_W-1:0]   cnt [N_OSC];
  logic [255:0]       resp_nxt;

  assign req = start & ~start_q & (state == IDLE);

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt = state;
    osc_clr   = 1'b0;
    osc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = MEASURE;
          osc_clr   = 1'b1;
        end
      end
      MEASURE: begin
        osc_en = 1'b1;
        if (win_cnt == '0) state_nxt = COMPARE;
      end
      COMPARE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Window down-counter, loaded on accept; terminal count ends MEASURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (req) begin
      win_cnt <= WIN_INIT;
    end else if (state == MEASURE && win_cnt != '0) begin
      win_cnt <= win_cnt - 1'b1;
    end
  end

  // Start edge history and challenge latch (frozen for the whole measurement).
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      ch_q    <= '0;
    end else begin
      start_q <= start;
      if (req) ch_q <= challenge;
    end
  end

`ifdef PUF_NOISE_EN
  logic [15:0] lfsr;

  // Jitter source: reseeded per request, advances every MEASURE cycle.
  always_ff @(posedge clk) begin
    if (rst || req)       lfsr <= LFSR_SEED;
    else if (osc_en)      lfsr <= lfsr_step(lfsr);
  end

  // The oscillator selected by the low LFSR nibble gains one extra count.
  always_comb begin
    jit = '0;
    if (osc_en) jit[lfsr[3:0]] = 1'b1;
  end
`else
  assign jit = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_OSC; gi++) begin : g_osc
      ro_model u_osc (
        .clk    (clk),
        .rst    (rst),
        .clr    (osc_clr),
        .en     (osc_en),
        .rate   (INC[gi]),
        .jitter (jit[gi]),
        .cnt    (cnt[gi])
      );
    end
  endgenerate

  // Bit k compares oscillator (k[7:4]^ca) against (k[3:0]^cb); ties give 0.
  always_comb begin
    resp_nxt = '0;
    for (int k = 0; k < 256; k++) begin
      resp_nxt[k] = cnt[4'(k / 16) ^ ch_q[7:4]] > cnt[4'(k % 16) ^ ch_q[3:0]];
    end
  end

  // Response capture and one-cycle done pulse on COMPARE.
  always_ff @(posedge clk) begin
    if (rst) begin
      response <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == COMPARE);
      if (state == COMPARE) response <= resp_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ro_puf.sv
`timescale 1ns/1ps
module tb_ro_puf;

  logic         clk = 1'b0;
  logic         rst, rst1;
  logic         start, start1;
  logic [7:0]   challenge, challenge1;
  logic [255:0] response, response1;
  logic         busy, busy1, done, done1;

  int n_chk  = 0;
  int n_fail = 0;

  int inc_tab [16] = '{8, 13, 4, 16, 1, 10, 6, 15, 2, 11, 14, 3, 9, 12, 5, 7};

  always #5 clk = ~clk;

  ro_puf #(.WINDOW(64)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .response(response), .busy(busy), .done(done)
  );

  ro_puf #(.WINDOW(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .challenge(challenge1),
    .response(response1), .busy(busy1), .done(done1)
  );

  // Reference response: counts are inc*window, bit k compares permuted pair.
  function automatic logic [255:0] model(input logic [7:0] ch, input int w);
    logic [255:0] r;
    int a, b;
    r = '0;
    for (int k = 0; k < 256; k++) begin
      a = (k / 16) ^ int'(ch[7:4]);
      b = (k % 16) ^ int'(ch[3:0]);
      r[k] = (inc_tab[a] * w) > (inc_tab[b] * w);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done (counting from the accept edge already passed), bounded.
  task automatic wait_done(input int k0, output int k, output int ndone);
    k = k0;
    ndone = 0;
    while (k < 300) begin
      tick();
      k++;
      if (done) begin
        ndone++;
        break;
      end
    end
  endtask

  task automatic count_idle_dones(input int n, output int ndone);
    ndone = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done || busy) ndone++;
    end
  endtask

  task automatic test_reset();
    int act;
    rst = 1'b1; start = 1'b0; challenge = 8'h00;
    tick(); tick();
    n_chk++;
    if (response !== 256'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: resp_nz=%0b busy=%b done=%b, required 0/0/0",
               response != 0, busy, done);
    end
    rst = 1'b0;
    count_idle_dones(10, act);
    n_chk++;
    if (act !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d active cycles with start low, required 0", act);
    end
  endtask

  task automatic test_basic();
    int k, nd, diag;
    challenge = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    wait_done(0, k, nd);
    n_chk++;
    if (k !== 65 || nd !== 1) begin
      n_fail++; $display("FAIL basic_latency: done at %0d cycles required 65", k);
    end
    n_chk++;
    if (response[8'h34] !== 1'b1 || response[8'h43] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_bits: r34=%b r43=%b required 1/0", response[8'h34], response[8'h43]);
    end
    diag = 0;
    for (int i = 0; i < 16; i++) if (response[i*17] !== 1'b0) diag++;
    n_chk++;
    if (diag !== 0) begin
      n_fail++; $display("FAIL basic_diag: %0d diagonal ones required 0", diag);
    end
    n_chk++;
    if ($countones(response) !== 120) begin
      n_fail++; $display("FAIL basic_pop: popcount %0d required 120", $countones(response));
    end
    n_chk++;
    if (response !== model(8'h00, 64)) begin
      n_fail++; $display("FAIL basic_resp: response %h required %h", response, model(8'h00, 64));
    end
    tick();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_after: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_held_start();
    int k, nd, extra;
    challenge = 8'h3C; start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    wait_done(2, k, nd);
    n_chk++;
    if (k !== 65 || nd !== 1) begin
      n_fail++; $display("FAIL held_latency: done at %0d cycles required 65", k);
    end
    n_chk++;
    if (response[8'h00] !== 1'b1 || response[8'h3C] !== 1'b0) begin
      n_fail++;
      $display("FAIL held_bits: r00=%b r3C=%b required 1/0", response[8'h00], response[8'h3C]);
    end
    n_chk++;
    if ($countones(response) !== 120) begin
      n_fail++; $display("FAIL held_pop: popcount %0d required 120", $countones(response));
    end
    count_idle_dones(80, extra);
    n_chk++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL held_single: %0d extra active cycles required 0", extra);
    end
  endtask

  task automatic test_ignore_during_measure();
    int k, nd, extra;
    challenge = 8'h5A; start = 1'b1;
    tick();
    start = 1'b0; challenge = 8'hFF;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      challenge = 8'(i * 37);
      tick();
      k++;
    end
    start = 1'b0;
    wait_done(k, k, nd);
    n_chk++;
    if (k !== 65 || nd !== 1) begin
      n_fail++; $display("FAIL ignore_latency: done at %0d cycles required 65", k);
    end
    n_chk++;
    if (response !== model(8'h5A, 64)) begin
      n_fail++; $display("FAIL ignore_resp: response %h required %h", response, model(8'h5A, 64));
    end
    count_idle_dones(80, extra);
    n_chk++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL ignore_single: %0d extra active cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid_measure();
    int k, nd, extra;
    challenge = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0 || response !== 256'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b resp_nz=%0b done=%b required 0/0/0",
               busy, response != 0, done);
    end
    rst = 1'b0;
    count_idle_dones(80, extra);
    n_chk++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL abort_nodone: %0d active cycles required 0", extra);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, k, nd);
    n_chk++;
    if (k !== 65 || nd !== 1 || response !== model(8'hA5, 64)) begin
      n_fail++;
      $display("FAIL abort_rerun: done at %0d (req 65), resp %h required %h",
               k, response, model(8'hA5, 64));
    end
  endtask

  task automatic test_window_one();
    // start held high through reset release triggers on the first edge
    rst1 = 1'b1; start1 = 1'b1; challenge1 = 8'h00;
    tick();
    rst1 = 1'b0;
    tick();
    start1 = 1'b0;
    n_chk++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL w1_start_thru_reset: busy=%b required 1", busy1);
    end
    tick();
    n_chk++;
    if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL w1_early: done=%b required 0 one cycle after accept", done1);
    end
    tick();
    n_chk++;
    if (done1 !== 1'b1 || response1 !== model(8'h00, 64) || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL w1_result: done=%b busy=%b resp %h required %h",
               done1, busy1, response1, model(8'h00, 64));
    end
    tick();
    challenge1 = 8'h3C; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick();
    n_chk++;
    if (done1 !== 1'b1 || response1 !== model(8'h3C, 64)) begin
      n_fail++;
      $display("FAIL w1_second: done=%b resp %h required %h", done1, response1, model(8'h3C, 64));
    end
    tick();
    n_chk++;
    if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL w1_pulse: done=%b required 0", done1);
    end
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    start = 1'b0; start1 = 1'b0;
    challenge = 8'h00; challenge1 = 8'h00;
    test_reset();
    test_basic();
    test_held_start();
    test_ignore_during_measure();
    test_reset_mid_measure();
    test_window_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
